// File: rtl/i2c_host_sequencer.sv
// i2c_host_sequencer: turns one host register request into I2C master FSM controls and returns one response.
// Optional watchdog: define I2C_SEQ_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYC cycles.
module i2c_host_sequencer #(
    parameter logic [6:0] SLAVE_ADDR = 7'h48,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_ptr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    input  logic        Ready,
    input  logic        Repeat,
    input  logic        Data_valid,
    input  logic        Error,
    input  logic [7:0]  Data_rx,
    output logic        Start,
    output logic        R_W,
    output logic        Set_pointer,
    output logic        Return,
    output logic [7:0]  Pointer,
    output logic [7:0]  Addr_byte,
    output logic [7:0]  Wdata_msb,
    output logic [7:0]  Wdata_lsb
);
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, RSTART, DONE} state_t;
    state_t state;
    logic [1:0] op, cnt, cnt_n, exp_n;
    logic err_q, dv_q, is_read, busy, take, err_n, fin_err;
    logic [15:0] data_n, fin_data;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [12:0] TMAX = 13'(TIMEOUT_CYC - 1);
    logic [12:0] tcnt;
`endif
    assign req_ready = state == IDLE;
    assign Addr_byte = {SLAVE_ADDR, R_W};
    assign is_read = op != 2'b01;
    assign busy = state == RUN || state == RSTART;
    assign exp_n = Pointer[1:0] == 2'b01 ? 2'd1 : 2'd2;
    // Only bytes a read still expects are captured; later edges are dropped.
    assign take = busy && Data_valid && !dv_q && is_read && cnt < exp_n;
    assign cnt_n = take ? cnt + 2'd1 : cnt;
    assign data_n = !take ? rsp_data : cnt == 2'd0 ? {Data_rx, rsp_data[7:0]} : {rsp_data[15:8], Data_rx};
    assign err_n = err_q | (busy && Error);
    assign fin_err = err_n | (is_read && cnt_n < exp_n);
    assign fin_data = !is_read ? 16'h0000 : exp_n == 2'd1 ? {8'h00, data_n[15:8]} : data_n;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            op <= 2'b00;
            cnt <= 2'd0;
            err_q <= 1'b0;
            dv_q <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= 16'h0000;
            rsp_error <= 1'b0;
            Start <= 1'b0;
            R_W <= 1'b0;
            Set_pointer <= 1'b0;
            Return <= 1'b0;
            Pointer <= 8'h00;
            Wdata_msb <= 8'h00;
            Wdata_lsb <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
            tcnt <= 13'd0;
`endif
        end else begin
            dv_q <= Data_valid;
            unique case (state)
                IDLE: if (req_valid) begin
                    op <= req_op;
                    Pointer <= req_ptr;
                    Wdata_msb <= req_wdata[15:8];
                    Wdata_lsb <= req_wdata[7:0];
                    cnt <= 2'd0;
                    err_q <= 1'b0;
                    rsp_data <= 16'h0000;
                    R_W <= req_op == 2'b00;
                    Set_pointer <= req_op == 2'b10;
                    rsp_error <= req_op == 2'b11;
                    rsp_valid <= req_op == 2'b11;
                    Start <= req_op != 2'b11 && Ready;
                    state <= req_op == 2'b11 ? DONE : LAUNCH;
                end
                LAUNCH: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    tcnt <= 13'd0;
`endif
                    // Start is held off while the FSM is still busy from an earlier abort.
                    Start <= Start && !Ready ? 1'b0 : Ready;
                    if (Start && !Ready) state <= RUN;
                end
                RUN, RSTART: begin
                    cnt <= cnt_n;
                    rsp_data <= data_n;
                    err_q <= err_n;
`ifdef I2C_SEQ_TIMEOUT_EN
                    tcnt <= tcnt + 13'd1;
                    if (tcnt == TMAX) begin
                        Start <= 1'b0;
                        Return <= 1'b0;
                        rsp_data <= 16'hDEAD;
                        rsp_error <= 1'b1;
                        rsp_valid <= 1'b1;
                        state <= DONE;
                    end else
`endif
                    if (state == RSTART) begin
                        if (!Repeat) begin
                            Return <= 1'b0;
                            state <= RUN;
                        end
                    end else if (Repeat && Set_pointer) begin
                        R_W <= 1'b1;
                        Set_pointer <= 1'b0;
                        Return <= 1'b1;
                        state <= RSTART;
                    end else if (Ready) begin
                        rsp_data <= fin_data;
                        rsp_error <= fin_err;
                        rsp_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_host_sequencer.sv
// tb_i2c_host_sequencer: directed bench with a response scoreboard and an I2C master FSM stand-in.
module tb_i2c_host_sequencer;
    logic Clk = 1'b0, Rst = 1'b0;
    logic req_valid = 1'b0, rsp_ready = 1'b1;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_ptr = 8'h00, Data_rx = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic Ready = 1'b1, Repeat = 1'b0, Data_valid = 1'b0, Error = 1'b0;
    logic req_ready, rsp_valid, rsp_error, Start, R_W, Set_pointer, Return;
    logic [15:0] rsp_data;
    logic [7:0] Pointer, Addr_byte, Wdata_msb, Wdata_lsb;
    typedef struct packed {logic [15:0] d; logic e;} rsp_t;
    rsp_t sb[$];
    rsp_t exp_r;
    int checks = 0, passes = 0;

    always #5 Clk = ~Clk;

    i2c_host_sequencer dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_ptr(req_ptr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .Ready(Ready), .Repeat(Repeat),
        .Data_valid(Data_valid), .Error(Error), .Data_rx(Data_rx), .Start(Start), .R_W(R_W),
        .Set_pointer(Set_pointer), .Return(Return), .Pointer(Pointer), .Addr_byte(Addr_byte),
        .Wdata_msb(Wdata_msb), .Wdata_lsb(Wdata_lsb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge Clk) begin
        if (Rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rsp: got data %h err %b with no request pending", rsp_data, rsp_error);
            end else begin
                exp_r = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(exp_r.d));
                check("rsp_error", 32'(rsp_error), 32'(exp_r.e));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] ptr, input logic [15:0] wd,
                         input logic [15:0] ed, input logic ee, input bit push);
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_ptr = ptr; req_wdata = wd;
        if (push) sb.push_back('{ed, ee});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic launch();
        for (int i = 0; i < 20 && !Start; i++) tick();
        check("start_high", 32'(Start), 32'd1);
        Ready = 1'b0;
        tick();
        check("start_drop", 32'(Start), 32'd0);
    endtask

    task automatic rx(input logic [7:0] b);
        Data_valid = 1'b1; Data_rx = b;
        tick();
        Data_valid = 1'b0;
        tick();
    endtask

    task automatic finish_txn();
        Ready = 1'b1;
        tick(2);
    endtask

    initial begin
        tick(2);
        check("rst_start", 32'(Start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_addr", 32'(Addr_byte), 32'h90);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        Rst = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        // two-byte read at pointer 0
        issue(2'b00, 8'h00, 16'h0000, 16'h1980, 1'b0, 1);
        launch();
        check("rd_rw", 32'(R_W), 32'd1);
        check("rd_addr", 32'(Addr_byte), 32'h91);
        check("rd_setptr", 32'(Set_pointer), 32'd0);
        rx(8'h19); rx(8'h80); finish_txn();
        // pointer + data write
        issue(2'b01, 8'h02, 16'h4B00, 16'h0000, 1'b0, 1);
        launch();
        check("wr_rw", 32'(R_W), 32'd0);
        check("wr_addr", 32'(Addr_byte), 32'h90);
        check("wr_msb", 32'(Wdata_msb), 32'h4B);
        check("wr_lsb", 32'(Wdata_lsb), 32'h00);
        check("wr_ptr", 32'(Pointer), 32'h02);
        finish_txn();
        // set pointer then single-byte read through repeated start
        issue(2'b10, 8'h01, 16'h0000, 16'h0060, 1'b0, 1);
        launch();
        check("rs_setptr", 32'(Set_pointer), 32'd1);
        Repeat = 1'b1;
        tick();
        check("rs_return", 32'(Return), 32'd1);
        check("rs_addr", 32'(Addr_byte), 32'h91);
        check("rs_setptr_clr", 32'(Set_pointer), 32'd0);
        tick();
        check("rs_return_hold", 32'(Return), 32'd1);
        Repeat = 1'b0;
        tick();
        check("rs_return_clr", 32'(Return), 32'd0);
        rx(8'h60); finish_txn();
        // write with NACK error
        issue(2'b01, 8'h03, 16'h1234, 16'h0000, 1'b1, 1);
        launch();
        Error = 1'b1; tick(); Error = 1'b0;
        finish_txn();
        // read with no data (address NACK)
        issue(2'b00, 8'h00, 16'h0000, 16'h0000, 1'b1, 1);
        launch(); finish_txn();
        // short read: one of two bytes
        issue(2'b00, 8'h00, 16'h0000, 16'h7700, 1'b1, 1);
        launch(); rx(8'h77); finish_txn();
        // error and data edge in the same cycle both recorded
        issue(2'b00, 8'h00, 16'h0000, 16'h1234, 1'b1, 1);
        launch();
        Error = 1'b1; Data_valid = 1'b1; Data_rx = 8'h12;
        tick();
        Error = 1'b0; Data_valid = 1'b0;
        tick();
        rx(8'h34); finish_txn();
        // single-byte read ignores an extra byte
        issue(2'b00, 8'h05, 16'h0000, 16'h00AB, 1'b0, 1);
        launch(); rx(8'hAB); rx(8'hCD); finish_txn();
        // reserved op
        issue(2'b11, 8'h00, 16'h0000, 16'h0000, 1'b1, 1);
        check("op11_valid", 32'(rsp_valid), 32'd1);
        check("op11_start", 32'(Start), 32'd0);
        tick(2);
        // reset during RUN discards the request
        issue(2'b00, 8'h00, 16'h0000, 16'h0000, 1'b0, 0);
        launch(); rx(8'h55);
        Rst = 1'b0;
        #1;
        check("abort_start", 32'(Start), 32'd0);
        check("abort_rsp_data", 32'(rsp_data), 32'd0);
        check("abort_addr", 32'(Addr_byte), 32'h90);
        check("abort_ptr", 32'(Pointer), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        Ready = 1'b1;
        tick();
        Rst = 1'b1;
        tick();
        check("abort_req_ready", 32'(req_ready), 32'd1);
`ifdef I2C_SEQ_TIMEOUT_EN
        issue(2'b00, 8'h00, 16'h0000, 16'hDEAD, 1'b1, 1);
        launch();
        for (int i = 0; i < 5000 && !rsp_valid; i++) tick();
        check("timeout_rsp", 32'(rsp_valid), 32'd1);
        tick();
        Ready = 1'b1;
        tick();
`endif
        tick(3);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
